// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset sequencer and its timer.
package reset_pkg;

  // Sequencer phases: all domains held, staggered release, all released.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  // Encodings reported on rst_cause for the source of the last sequence.
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Width of the domain index register; never narrower than one bit.
  function automatic int idx_width(input int num_domains);
    return (num_domains > 1) ? $clog2(num_domains) : 1;
  endfunction

endpackage

// File: rtl/reset_timer.sv
// Up-counter with synchronous clear and a terminal-compare flag against a
// limit supplied at runtime, so one counter serves both timed phases.
module reset_timer
  import reset_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] cnt;

  // Count every cycle; clear restarts the interval from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == limit);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains for a minimum pulse, then releases them one at a
// time in index order. A software request edge or a watchdog pulse restarts
// the whole sequence; the source of the last sequence is reported.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int PULSE_CYCLES   = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n_in,
  input  logic                   sw_rst_req,
  input  logic                   wdt_expire,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic                   req_ack,
  output logic [1:0]             rst_cause
);

  localparam int IDX_W = idx_width(NUM_DOMAINS);
  localparam logic [CNT_WIDTH-1:0] PULSE_LIMIT   = CNT_WIDTH'(PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGGER_LIMIT = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX      = IDX_W'(NUM_DOMAINS - 1);

  seq_state_t             state;
  logic [IDX_W-1:0]       idx;
  logic                   sw_prev;
  logic                   req;
  logic                   tmr_clr;
  logic                   tmr_done;
  logic [CNT_WIDTH-1:0]   tmr_limit;
  logic [NUM_DOMAINS-1:0] idx_mask;

  // A rising software level or any watchdog pulse is a request.
  assign req = (sw_rst_req & ~sw_prev) | wdt_expire;

  // One shared timer; its interval depends on which phase is running.
  assign tmr_limit = (state == HOLD) ? PULSE_LIMIT : STAGGER_LIMIT;
  assign tmr_clr   = req | tmr_done | (state == RUN);
  assign idx_mask  = NUM_DOMAINS'(1) << idx;

  reset_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n_in),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // Sequencer FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= HOLD;
      idx       <= '0;
      // NOTE: sw_prev resets high so a request level held through reset is
      // not seen as a new rising edge once reset releases.
      sw_prev   <= 1'b1;
      rst_n_out <= '0;
      busy      <= 1'b1;
      req_ack   <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      sw_prev <= sw_rst_req;
      req_ack <= 1'b0;
      if (req) begin
        // Any accepted request restarts the full sequence from scratch.
        state     <= HOLD;
        idx       <= '0;
        rst_n_out <= '0;
        busy      <= 1'b1;
        req_ack   <= 1'b1;
        rst_cause <= wdt_expire ? CAUSE_WDT : CAUSE_SW;
      end else begin
        unique case (state)
          HOLD: begin
            if (tmr_done) begin
              rst_n_out[0] <= 1'b1;
              if (NUM_DOMAINS == 1) begin
                state <= RUN;
                busy  <= 1'b0;
              end else begin
                state <= STAGGER;
                idx   <= IDX_W'(1);
              end
            end
          end
          STAGGER: begin
            if (tmr_done) begin
              rst_n_out <= rst_n_out | idx_mask;
              idx       <= idx + 1'b1;
              if (idx == LAST_IDX) begin
                state <= RUN;
                busy  <= 1'b0;
              end
            end
          end
          RUN: begin
            rst_n_out <= '1;
            busy      <= 1'b0;
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 3-domain instance plus a
// single-domain, minimum-pulse instance sharing the clock and reset.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n_in;
  logic       sw_rst_req;
  logic       wdt_expire;
  logic [2:0] rst_n_out;
  logic       busy;
  logic       req_ack;
  logic [1:0] rst_cause;

  logic       s_rst_n_out;
  logic       s_busy;
  logic       s_req_ack;
  logic [1:0] s_rst_cause;

  int tests = 0;
  int fails = 0;
  int edge_num = 0;
  int ack_cnt = 0;
  int s_ack_cnt = 0;
  int ack_base;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk        (clk),
    .rst_n_in   (rst_n_in),
    .sw_rst_req (sw_rst_req),
    .wdt_expire (wdt_expire),
    .rst_n_out  (rst_n_out),
    .busy       (busy),
    .req_ack    (req_ack),
    .rst_cause  (rst_cause)
  );

  reset_sequencer #(
    .NUM_DOMAINS    (1),
    .PULSE_CYCLES   (2),
    .STAGGER_CYCLES (1),
    .CNT_WIDTH      (4)
  ) dut_single (
    .clk        (clk),
    .rst_n_in   (rst_n_in),
    .sw_rst_req (1'b0),
    .wdt_expire (1'b0),
    .rst_n_out  (s_rst_n_out),
    .busy       (s_busy),
    .req_ack    (s_req_ack),
    .rst_cause  (s_rst_cause)
  );

  // Tally acknowledge pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (req_ack) ack_cnt++;
    if (s_req_ack) s_ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n (edges counted from release).
  task automatic to_edge(input int n);
    while (edge_num < n) begin
      @(posedge clk);
      edge_num++;
    end
    #1;
  endtask

  // Deassert reset just after an edge so the next rising edge is edge 1.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n_in = 1'b1;
    edge_num = 0;
  endtask

  initial begin
    rst_n_in   = 1'b0;
    sw_rst_req = 1'b0;
    wdt_expire = 1'b0;
    #12;
    check("reset_out",   32'(rst_n_out), 32'h0);
    check("reset_busy",  32'(busy),      32'h1);
    check("reset_ack",   32'(req_ack),   32'h0);
    check("reset_cause", 32'(rst_cause), 32'h0);
    release_reset();

    // Power-on sequence, default timing.
    to_edge(1);
    check("single_e1_out",  32'(s_rst_n_out), 32'h0);
    check("single_e1_busy", 32'(s_busy),      32'h1);
    to_edge(2);
    check("single_e2_out",  32'(s_rst_n_out), 32'h1);
    check("single_e2_busy", 32'(s_busy),      32'h0);
    to_edge(15);
    check("por_e15", 32'(rst_n_out), 32'h0);
    to_edge(16);
    check("por_e16", 32'(rst_n_out), 32'h1);
    to_edge(23);
    check("por_e23", 32'(rst_n_out), 32'h1);
    to_edge(24);
    check("por_e24", 32'(rst_n_out), 32'h3);
    to_edge(31);
    check("por_e31",      32'(rst_n_out), 32'h3);
    check("por_e31_busy", 32'(busy),      32'h1);
    to_edge(32);
    check("por_e32",       32'(rst_n_out), 32'h7);
    check("por_e32_busy",  32'(busy),      32'h0);
    check("por_cause",     32'(rst_cause), 32'h0);
    check("por_no_ack",    32'(ack_cnt),   32'h0);
    check("single_no_ack", 32'(s_ack_cnt), 32'h0);

    // Software request in RUN, level then held high.
    to_edge(49);
    sw_rst_req = 1'b1;
    ack_base = ack_cnt;
    to_edge(50);
    check("sw_e50_out",   32'(rst_n_out), 32'h0);
    check("sw_e50_busy",  32'(busy),      32'h1);
    check("sw_e50_ack",   32'(req_ack),   32'h1);
    check("sw_e50_cause", 32'(rst_cause), 32'h1);
    to_edge(51);
    check("sw_e51_ack", 32'(req_ack), 32'h0);
    to_edge(65);
    check("sw_e65", 32'(rst_n_out), 32'h0);
    to_edge(66);
    check("sw_e66", 32'(rst_n_out), 32'h1);
    to_edge(74);
    check("sw_e74", 32'(rst_n_out), 32'h3);
    to_edge(82);
    check("sw_e82",        32'(rst_n_out),      32'h7);
    check("sw_e82_busy",   32'(busy),           32'h0);
    check("sw_single_ack", 32'(ack_cnt - ack_base), 32'h1);

    // Simultaneous software edge and watchdog pulse: watchdog wins.
    to_edge(83);
    sw_rst_req = 1'b0;
    to_edge(89);
    sw_rst_req = 1'b1;
    wdt_expire = 1'b1;
    ack_base = ack_cnt;
    to_edge(90);
    wdt_expire = 1'b0;
    check("both_out",   32'(rst_n_out), 32'h0);
    check("both_ack",   32'(req_ack),   32'h1);
    check("both_cause", 32'(rst_cause), 32'h2);
    to_edge(91);
    check("both_ack_once", 32'(ack_cnt - ack_base), 32'h1);

    // Async reset mid-stagger with the software level held high.
    to_edge(114);
    check("pre_async_out", 32'(rst_n_out), 32'h3);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("async_out",   32'(rst_n_out), 32'h0);
    check("async_busy",  32'(busy),      32'h1);
    check("async_ack",   32'(req_ack),   32'h0);
    check("async_cause", 32'(rst_cause), 32'h0);
    repeat (2) @(posedge clk);
    release_reset();
    ack_base = ack_cnt;
    to_edge(16);
    check("rel_e16",    32'(rst_n_out),          32'h1);
    check("rel_no_ack", 32'(ack_cnt - ack_base), 32'h0);

    // Watchdog pulse mid-stagger.
    to_edge(19);
    wdt_expire = 1'b1;
    to_edge(20);
    wdt_expire = 1'b0;
    check("wdt_e20_out",   32'(rst_n_out), 32'h0);
    check("wdt_e20_ack",   32'(req_ack),   32'h1);
    check("wdt_e20_cause", 32'(rst_cause), 32'h2);
    to_edge(21);
    check("wdt_e21_ack", 32'(req_ack), 32'h0);
    to_edge(35);
    check("wdt_e35", 32'(rst_n_out), 32'h0);
    to_edge(36);
    check("wdt_e36", 32'(rst_n_out), 32'h1);
    to_edge(44);
    check("wdt_e44", 32'(rst_n_out), 32'h3);
    to_edge(51);
    check("wdt_e51_busy", 32'(busy), 32'h1);
    to_edge(52);
    check("wdt_e52",       32'(rst_n_out), 32'h7);
    check("wdt_e52_busy",  32'(busy),      32'h0);
    check("wdt_cause_hold", 32'(rst_cause), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
